// File: rtl/bus_router_n.sv
// bus_router_n: N-port address-decoding router with valid/ready flow control.
// One request stream in, each accepted request forwarded to exactly one port
// selected by ascending region bases. Every port has a one-entry registered
// output stage, so a stalled port never blocks traffic to other ports.
// Requests below the first base are dropped and reported on err/err_addr.
// Optional feature: define ROUTE_CNT_EN to build saturating per-port accept
// counters on cnt; otherwise cnt is tied to 0.
`timescale 1ns/1ps

module bus_router_n #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter logic [NUM_PORTS*ADDR_W-1:0] PORT_BASE = {8'hC0, 8'h80, 8'h40, 8'h00}
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic [ADDR_W-1:0]           in_addr,
  input  logic [DATA_W-1:0]           in_data,
  output logic [NUM_PORTS-1:0]        out_vld,
  input  logic [NUM_PORTS-1:0]        out_rdy,
  output logic [NUM_PORTS*ADDR_W-1:0] out_addr,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic                        err,
  output logic [ADDR_W-1:0]           err_addr,
  output logic [NUM_PORTS*16-1:0]     cnt
);

  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic                 hit;
  logic [SEL_W-1:0]     sel;
  logic [NUM_PORTS-1:0] stage_free;
  logic [NUM_PORTS-1:0] load;
  logic                 accept;

  // Address decode: bases ascend, so the highest base not above in_addr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_addr >= PORT_BASE[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

  // A stage can take a new entry when empty or when it drains this cycle.
  assign stage_free = ~out_vld | out_rdy;

  // Unmapped requests are always consumed; mapped ones wait for their stage.
  assign in_rdy = rstn && (!hit || stage_free[sel]);
  assign accept = in_vld && in_rdy;

  // One-hot load strobe for the stage selected by the decoder.
  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      load[i] = accept && hit && (sel == SEL_W'(i));
    end
  end

  // Per-port output stages: load wins over drain, drain clears the entry to 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: addr/data are reset along with vld because idle ports must read 0.
      out_vld  <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (load[i]) begin
          // NOTE: sequential state uses non-blocking assignments only.
          out_vld[i]                   <= 1'b1;
          out_addr[i*ADDR_W +: ADDR_W] <= in_addr;
          out_data[i*DATA_W +: DATA_W] <= in_data;
        end else if (out_vld[i] && out_rdy[i]) begin
          out_vld[i]                   <= 1'b0;
          out_addr[i*ADDR_W +: ADDR_W] <= '0;
          out_data[i*DATA_W +: DATA_W] <= '0;
        end
      end
    end
  end

  // Drop reporting: single-cycle pulse and sticky copy of the dropped address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      err <= accept && !hit;
      if (accept && !hit) begin
        err_addr <= in_addr;
      end
    end
  end

`ifdef ROUTE_CNT_EN
  logic [15:0] cnt_q [NUM_PORTS];

  // Saturating accept counters, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (load[i] && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Pack the counter array onto the flat output bus.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`else
  assign cnt = '0;
`endif

endmodule

// File: tb/tb_bus_router_n.sv
// Testbench for bus_router_n: directed vectors with a per-port scoreboard.
// Stimulus pushes expected entries; a negedge monitor pops and compares on
// every output handshake and on every err pulse.
`timescale 1ns/1ps

module tb_bus_router_n;

  localparam int NP = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam logic [NP*AW-1:0] BASE = {8'hC0, 8'h80, 8'h40, 8'h10};

  logic           clk = 1'b0;
  logic           rstn;
  logic           in_vld;
  logic           in_rdy;
  logic [AW-1:0]  in_addr;
  logic [DW-1:0]  in_data;
  logic [NP-1:0]  out_vld;
  logic [NP-1:0]  out_rdy;
  logic [NP*AW-1:0] out_addr;
  logic [NP*DW-1:0] out_data;
  logic           err;
  logic [AW-1:0]  err_addr;
  logic [NP*16-1:0] cnt;

  bus_router_n #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PORT_BASE(BASE)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_addr(out_addr), .out_data(out_data),
    .err(err), .err_addr(err_addr), .cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [AW-1:0] addr;
  } err_exp_t;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  bit          mon_en = 1'b0;
  bit          rand_en = 1'b0;
  logic [AW+DW-1:0] exp_q [NP][$];
  err_exp_t    err_q [$];
  int          sent [NP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode for the random stream: regions start at 10/40/80/C0.
  function automatic int port_of(input logic [AW-1:0] a);
    if (a >= 8'hC0) return 3;
    if (a >= 8'h80) return 2;
    if (a >= 8'h40) return 1;
    if (a >= 8'h10) return 0;
    return -1;
  endfunction

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d, input int p);
    if (p < 0) begin
      err_q.push_back('{cyc + 1, a});
    end else begin
      exp_q[p].push_back({a, d});
      sent[p]++;
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < NP; i++) begin
      exp_q[i].delete();
      sent[i] = 0;
    end
    err_q.delete();
  endtask

  // Drive one request; returns cycles spent waiting for in_rdy. Ends at posedge+1.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input int p,
                      output int waits);
    in_vld  = 1'b1;
    in_addr = a;
    in_data = d;
    waits   = 0;
    @(negedge clk);
    while (!in_rdy && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_rdy) begin
      check("send_timeout", 32'(waits), 32'd0);
      @(posedge clk); #1;
      in_vld = 1'b0;
    end else begin
      push_exp(a, d, p);
      @(posedge clk); #1;
      in_vld = 1'b0;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Random backpressure during the random phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_en) out_rdy = NP'($urandom);
    end
  end

  // Monitor: idle ports read 0; every handshake pops the port's expectation.
  always @(negedge clk) begin
    if (rstn && mon_en) begin
      for (int i = 0; i < NP; i++) begin
        if (!out_vld[i]) begin
          check($sformatf("idle_zero_p%0d", i),
                32'({out_addr[i*AW +: AW], out_data[i*DW +: DW]}), 32'd0);
        end else if (out_rdy[i]) begin
          check($sformatf("out_expected_p%0d", i), 32'(exp_q[i].size() != 0), 32'd1);
          if (exp_q[i].size() != 0) begin
            logic [AW+DW-1:0] e;
            e = exp_q[i].pop_front();
            check($sformatf("route_p%0d", i),
                  32'({out_addr[i*AW +: AW], out_data[i*DW +: DW]}), 32'(e));
          end
        end
      end
      if (err) begin
        check("err_expected", 32'(err_q.size() != 0), 32'd1);
        if (err_q.size() != 0) begin
          err_exp_t f;
          f = err_q.pop_front();
          check("err_cycle", cyc, f.cyc);
          check("err_addr", 32'(err_addr), 32'(f.addr));
        end
      end else if (err_q.size() != 0 && err_q[0].cyc <= cyc) begin
        check("err_missed", 32'(err), 32'd1);
        void'(err_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n_cnt;
    rstn    = 1'b0;
    in_vld  = 1'b0;
    in_addr = '0;
    in_data = '0;
    out_rdy = '0;
    flush_model();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_err", 32'({err, err_addr}), 32'd0);
    rstn    = 1'b1;
    out_rdy = 4'b1111;
    mon_en  = 1'b1;
    @(negedge clk);
    check("idle_in_rdy", 32'(in_rdy), 32'd1);
    check("idle_out_vld", 32'(out_vld), 32'd0);
    check("idle_cnt", 32'(cnt[31:0] | cnt[63:32]), 32'd0);
    @(posedge clk); #1;

    // Basic routing, one-cycle latency.
    send(8'h3F, 16'h1234, 0, w);
    check("lat_vld_p0", 32'(out_vld), 32'h1);
    check("lat_addr_p0", 32'(out_addr[7:0]), 32'h3F);
    check("lat_data_p0", 32'(out_data[15:0]), 32'h1234);
    send(8'h40, 16'hA5A5, 1, w);
    check("lat_vld_p1", 32'(out_vld), 32'h2);
    check("lat_addr_p1", 32'(out_addr[15:8]), 32'h40);
    send(8'hFF, 16'hBEEF, 3, w);
    check("lat_vld_p3", 32'(out_vld), 32'h8);
    check("lat_data_p3", 32'(out_data[63:48]), 32'hBEEF);
    send(8'hBF, 16'h0042, 2, w);
    check("lat_vld_p2", 32'(out_vld), 32'h4);

    // Backpressure on port 1, independence of port 0, drain+load without bubble.
    out_rdy = 4'b1101;
    send(8'h50, 16'h5050, 1, w);
    send(8'h10, 16'h1010, 0, w);
    check("indep_wait", 32'(w), 32'd0);
    in_vld  = 1'b1;
    in_addr = 8'h60;
    in_data = 16'h6060;
    @(negedge clk);
    check("stall_rdy", 32'(in_rdy), 32'd0);
    check("hold_addr", 32'(out_addr[15:8]), 32'h50);
    @(negedge clk);
    check("stall_rdy2", 32'(in_rdy), 32'd0);
    check("hold_data", 32'(out_data[31:16]), 32'h5050);
    @(posedge clk); #1;
    out_rdy = 4'b1111;
    @(negedge clk);
    check("drain_load_rdy", 32'(in_rdy), 32'd1);
    if (in_rdy) push_exp(8'h60, 16'h6060, 1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    check("no_bubble_vld", 32'(out_vld[1]), 32'd1);
    check("no_bubble_addr", 32'(out_addr[15:8]), 32'h60);

    // Unmapped addresses, including back-to-back.
    send(8'h05, 16'hDEAD, -1, w);
    check("unmapped_wait", 32'(w), 32'd0);
    check("unmapped_err", 32'(err), 32'd1);
    check("unmapped_err_addr", 32'(err_addr), 32'h05);
    check("unmapped_no_vld", 32'(out_vld[0]), 32'd0);
    send(8'h00, 16'h0001, -1, w);
    send(8'h0F, 16'h0002, -1, w);
    check("b2b_err", 32'(err), 32'd1);
    check("b2b_err_addr", 32'(err_addr), 32'h0F);
    @(posedge clk); #1;
    check("err_clear", 32'(err), 32'd0);
    check("err_addr_sticky", 32'(err_addr), 32'h0F);

    // Asynchronous reset with port 2 holding an entry.
    out_rdy = 4'b1011;
    send(8'h90, 16'h9999, 2, w);
    check("pre_rst_vld", 32'(out_vld[2]), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_vld", 32'(out_vld), 32'd0);
    check("async_rst_addr", out_addr, 32'd0);
    check("async_rst_data", out_data[63:32], 32'd0);
    check("async_rst_rdy", 32'(in_rdy), 32'd0);
    check("async_rst_cnt", cnt[31:0], 32'd0);
    flush_model();
    out_rdy = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Random stream with random backpressure.
    rand_en = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'($urandom);
      d = DW'($urandom);
      send(a, d, port_of(a), w);
    end
    rand_en = 1'b0;
    @(posedge clk); #1;
    out_rdy = 4'b1111;

    // Counter saturation burst to port 0.
`ifdef ROUTE_CNT_EN
    n_cnt = 70000;
`else
    n_cnt = 100;
`endif
    for (int k = 0; k < n_cnt; k++) begin
      send(8'h20, DW'(k), 0, w);
    end
    repeat (4) @(posedge clk);
    #1;

    // Everything issued must have come out; counters match the model.
    for (int i = 0; i < NP; i++) begin
      check($sformatf("drained_p%0d", i), 32'(exp_q[i].size()), 32'd0);
`ifdef ROUTE_CNT_EN
      check($sformatf("cnt_p%0d", i), 32'(cnt[i*16 +: 16]),
            (sent[i] > 65535) ? 32'hFFFF : 32'(sent[i]));
`else
      check($sformatf("cnt_zero_p%0d", i), 32'(cnt[i*16 +: 16]), 32'd0);
`endif
    end
    check("err_drained", 32'(err_q.size()), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
